// File: rtl/deinterleaver_if.sv
// Symbol-stream bundle between the deinterleaver and its neighbours (input and output handshakes).
// Latency: none, this is a wiring bundle only.
// Backpressure: valid/ready on both sides; slave = deinterleaver, master = upstream/downstream environment.
interface deinterleaver_if #(
    parameter int DATA_W = 12
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/deinterleaver.sv
// Block deinterleaver: column-major symbols in, row-major out, two-bank ping-pong RAM; optional sequence check under DEINTLV_CHECK_EN.
// Latency: last accept at edge T -> first out_valid after edge T+2 (one cycle for the write to land, one for the RAM read).
// Backpressure: in_ready low while the write bank still holds an undrained frame; out_data/out_last held while out_ready is low.
module deinterleaver #(
    parameter int ROWS   = 8,
    parameter int COLS   = 16,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    deinterleaver_if.slave    bus,
    output logic [ADDR_W-1:0] decode_wr_addr,
    output logic [ADDR_W-1:0] decode_rd_addr
`ifdef DEINTLV_CHECK_EN
    ,
    output logic              check_out
`endif
);

    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int MW = $clog2(2 * N);

    localparam logic [ADDR_W-1:0] N_A       = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] OFF_LAST  = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    logic [DATA_W-1:0] mem [2*N];

    // write side
    logic [RW-1:0]     wr_row_q, wr_row_d;
    logic [CW-1:0]     wr_col_q, wr_col_d;
    logic [ADDR_W-1:0] wr_off_q, wr_off_d;
    logic              wbank_q, wbank_d;
    logic              wr_fire, wr_last;
    logic [1:0]        wr_st;

    // pending RAM write (registered write port)
    logic              wr_en_q;
    logic              wr_bank_q;
    logic [MW-1:0]     wr_addr_q;
    logic [DATA_W-1:0] wr_dat_q;

    // bank status
    logic [1:0]        bank_st_q [2];
    logic [1:0]        bank_st_d [2];

    // read side
    logic [ADDR_W-1:0] rd_off_q;
    logic              rbank_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_st;
    logic              rd_fire, rd_last, rd_blk;
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] decode_rd_addr_q;

    assign wr_st          = bank_st_q[wbank_q];
    assign rd_st          = bank_st_q[rbank_q];
    assign bus.in_ready   = !rst && ((wr_st == ST_EMPTY) || (wr_st == ST_FILLING));
    assign wr_fire        = bus.in_valid && bus.in_ready;
    assign wr_last        = (wr_row_q == ROW_LAST) && (wr_col_q == COL_LAST);
    assign decode_wr_addr = (wbank_q ? N_A : '0) + wr_off_q;

    // The last symbol of a frame lands in RAM one edge after it is accepted,
    // so the bank it went to may not be read until that write has retired.
    assign rd_blk  = wr_en_q && (wr_bank_q == rbank_q);
    assign rd_last = (rd_off_q == OFF_LAST);
    assign rd_addr = (rbank_q ? N_A : '0) + rd_off_q;
    assign rd_fire = ((rd_st == ST_FULL) || (rd_st == ST_DRAINING)) && !rd_blk
                     && (!out_valid_q || bus.out_ready);

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign decode_rd_addr = decode_rd_addr_q;

    // Incremental column-major -> row-major offset: +COLS down a column, col+1 at column wrap.
    always_comb begin
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        wr_off_d = wr_off_q;
        wbank_d  = wbank_q;
        if (wr_fire) begin
            if (wr_row_q == ROW_LAST) begin
                wr_row_d = '0;
                if (wr_col_q == COL_LAST) begin
                    wr_col_d = '0;
                    wr_off_d = '0;
                    wbank_d  = ~wbank_q;
                end else begin
                    wr_col_d = wr_col_q + 1'b1;
                    wr_off_d = ADDR_W'(wr_col_q) + ADDR_W'(1);
                end
            end else begin
                wr_row_d = wr_row_q + 1'b1;
                wr_off_d = wr_off_q + COLS_A;
            end
        end
    end

    // Write-side counters, bank pointer and the registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_off_q  <= '0;
            wbank_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_off_q  <= wr_off_d;
            wbank_q   <= wbank_d;
            wr_en_q   <= wr_fire;
            wr_bank_q <= wbank_q;
            wr_addr_q <= decode_wr_addr[MW-1:0];
            wr_dat_q  <= bus.in_data;
        end
    end

    // Bank lifecycle; a bank is never written and read in the same cycle, so each bank sees at most one event.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_d[b] = bank_st_q[b];
            if (wr_fire && (wbank_q == 1'(b)))
                bank_st_d[b] = wr_last ? ST_FULL : ST_FILLING;
            if (rd_fire && (rbank_q == 1'(b)))
                bank_st_d[b] = rd_last ? ST_EMPTY : ST_DRAINING;
        end
    end

    // Bank status registers.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (rst) bank_st_q[b] <= ST_EMPTY;
            else     bank_st_q[b] <= bank_st_d[b];
        end
    end

    // Symbol storage; contents need no reset because bank status gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_q) mem[wr_addr_q] <= wr_dat_q;
    end

    // Read side: the RAM output register is the out_data register and only reloads on an issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_off_q         <= '0;
            rbank_q          <= 1'b0;
            out_valid_q      <= 1'b0;
            out_last_q       <= 1'b0;
            out_data_q       <= '0;
            decode_rd_addr_q <= '0;
        end else if (rd_fire) begin
            out_data_q       <= mem[rd_addr[MW-1:0]];
            out_valid_q      <= 1'b1;
            out_last_q       <= rd_last;
            decode_rd_addr_q <= rd_addr;
            rd_off_q         <= rd_last ? '0 : rd_off_q + ADDR_W'(1);
            if (rd_last) rbank_q <= ~rbank_q;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

`ifdef DEINTLV_CHECK_EN
    logic [DATA_W-1:0] chk_cnt_q;
    logic              check_q;
    logic              out_hs;

    assign out_hs    = out_valid_q && bus.out_ready;
    assign check_out = check_q;

    // Compare each delivered symbol against a free-running sequence starting at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_cnt_q <= '0;
            check_q   <= 1'b0;
        end else begin
            check_q <= out_hs && (out_data_q != chk_cnt_q);
            if (out_hs) chk_cnt_q <= chk_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench for deinterleaver (ROWS=2, COLS=3) against a queue-based frame permutation model.
// Latency: checks first out_valid two cycles after the last accept of a frame.
// Backpressure: exercises full stall, toggled out_ready and random valid/ready.
module tb_deinterleaver;
    localparam int ROWS   = 2;
    localparam int COLS   = 3;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 12;
    localparam int N      = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deinterleaver_if #(.DATA_W(DATA_W)) bus ();
    logic [ADDR_W-1:0] wr_addr, rd_addr;
`ifdef DEINTLV_CHECK_EN
    logic check_out;
`endif

    deinterleaver #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .decode_wr_addr (wr_addr),
        .decode_rd_addr (rd_addr)
`ifdef DEINTLV_CHECK_EN
        ,
        .check_out      (check_out)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DATA_W-1:0] frame_buf[$];
    logic [DATA_W-1:0] exp_q[$];
    int                in_k, frame_cnt, out_cnt;
    logic              held_vld, held_last;
    logic [DATA_W-1:0] held_dat;
    logic              smp_ir, smp_ov, smp_acc;
    int                smp_ocnt;
    int                hs_cnt, ck_ones;
    logic              ck_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        frame_buf.delete();
        exp_q.delete();
        in_k      = 0;
        frame_cnt = 0;
        out_cnt   = 0;
        held_vld  = 1'b0;
        hs_cnt    = 0;
        ck_exp    = 1'b0;
        ck_ones   = 0;
    endtask

    // Input index k sits at row k%ROWS, column k/ROWS; emit the frame in row-major order.
    task automatic frame_done();
        logic [DATA_W-1:0] row_major [N];
        for (int k = 0; k < N; k++) row_major[(k % ROWS) * COLS + k / ROWS] = frame_buf[k];
        for (int p = 0; p < N; p++) exp_q.push_back(row_major[p]);
        frame_buf.delete();
    endtask

    // Column-major image of row-major values f*N .. f*N+N-1.
    function automatic logic [DATA_W-1:0] cm(input int f, input int k);
        return DATA_W'(f * N + (k % ROWS) * COLS + k / ROWS);
    endfunction

    function automatic logic ordy_of(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'(cyc % 2);
            default: return 1'($urandom % 2);
        endcase
    endfunction

    // One clock: drive at negedge, sample 1ns later, then account for the coming edge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic ordy);
        int                exp_addr;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        smp_ir   = bus.in_ready;
        smp_ov   = bus.out_valid;
        smp_ocnt = out_cnt;
        smp_acc  = iv && bus.in_ready;
        if (held_vld) begin
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_data", bus.out_data, held_dat);
            check_eq("hold_last", bus.out_last, held_last);
        end
        held_vld  = bus.out_valid && !ordy;
        held_dat  = bus.out_data;
        held_last = bus.out_last;
`ifdef DEINTLV_CHECK_EN
        check_eq("check_out", check_out, ck_exp);
        ck_ones += int'(check_out);
        ck_exp = bus.out_valid && ordy && (bus.out_data != DATA_W'(hs_cnt));
        if (bus.out_valid && ordy) hs_cnt++;
`endif
        if (smp_acc) begin
            exp_addr = (frame_cnt % 2) * N + (in_k % ROWS) * COLS + in_k / ROWS;
            check_eq("wr_addr", wr_addr, exp_addr);
            frame_buf.push_back(id);
            in_k++;
            if (in_k == N) begin
                frame_done();
                in_k = 0;
                frame_cnt++;
            end
        end
        if (bus.out_valid && ordy) begin
            check_eq("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("out_data", bus.out_data, e);
                check_eq("out_last", bus.out_last, (out_cnt % N) == N - 1);
                check_eq("rd_addr", rd_addr, ((out_cnt / N) % 2) * N + out_cnt % N);
            end
            out_cnt++;
        end
        cyc++;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_last", bus.out_last, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
`ifdef DEINTLV_CHECK_EN
        check_eq("rst_check_out", check_out, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", bus.in_ready, 1);
        model_clear();
    endtask

    task automatic feed(input logic [DATA_W-1:0] d, input int mode);
        for (int t = 0; t < 64; t++) begin
            step(1'b1, d, ordy_of(mode));
            if (smp_acc) return;
        end
        check_eq("feed_timeout", smp_acc, 1);
    endtask

    task automatic drain(input int mode);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) step(1'b0, '0, ordy_of(mode));
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_clear();
        do_reset(2);

        // basic order and first-output latency
        for (int k = 0; k < N; k++) feed(cm(0, k), 1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, '0, 1'b1);
            check_eq("latency_out_valid", smp_ov, i == 3);
        end
        drain(1);

        // back-to-back frames, no input stall
        do_reset(1);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) begin
                step(1'b1, cm(f, k), 1'b1);
                check_eq("b2b_in_ready", smp_ir, 1);
            end
        drain(1);

        // full backpressure: both banks fill, then release
        do_reset(1);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) feed(cm(f, k), 0);
        repeat (3) begin
            step(1'b1, cm(2, 0), 1'b0);
            check_eq("bp_full_in_ready", smp_ir, 0);
        end
        for (int t = 0; t < 100 && out_cnt < 2 * N; t++) begin
            step(1'b0, '0, 1'b1);
            check_eq("bp_in_ready", smp_ir, smp_ocnt >= 5);
        end
        check_eq("bp_drained", out_cnt, 2 * N);
        for (int k = 0; k < N; k++) feed(cm(2, k), 1);
        drain(1);

        // out_ready toggling every other cycle
        do_reset(1);
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N; k++) feed(cm(f, k), 2);
        drain(2);

        // reset mid-frame discards the partial frame
        do_reset(1);
        for (int k = 0; k < 3; k++) feed(cm(0, k), 1);
        do_reset(1);
        for (int k = 0; k < N; k++) feed(cm(5, k), 1);
        drain(1);
        repeat (4) begin
            step(1'b0, '0, 1'b1);
            check_eq("idle_out_valid", smp_ov, 0);
        end

        // random traffic
        do_reset(1);
        for (int t = 0; t < 300; t++)
            step(($urandom % 4) != 0, DATA_W'($urandom), ($urandom % 3) != 0);
        drain(1);

`ifdef DEINTLV_CHECK_EN
        // corrupted symbol at output index 4
        do_reset(1);
        begin
            logic [DATA_W-1:0] bad [N];
            bad = '{12'd0, 12'd3, 12'd1, 12'd5, 12'd2, 12'd5};
            for (int k = 0; k < N; k++) feed(bad[k], 1);
        end
        drain(1);
        repeat (2) step(1'b0, '0, 1'b1);
        check_eq("check_out_pulses", ck_ones, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
